// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl
//   Instruction-fetch controller sitting between the PC register and the
//   Decode pipeline register. A request carrying a PC starts a single-beat
//   read on an AXI4-Lite-style read channel. The returned word is held for
//   Decode under a valid/ready handshake. At most one fetch is in flight.
//   The next request may be accepted in the same cycle the held result is
//   consumed.
//
// Ports
//   clk, rst                     clock; synchronous active-high reset
//   req_valid/req_ready, req_pc  upstream fetch request
//   mem_arvalid/arready/araddr   read-address channel
//   mem_rvalid/rready/rdata/rresp read-data channel
//   out_valid/out_ready          downstream handshake
//   out_pc, out_inst, fault_o    fetched result; fault forces NOP_INST
module ifu_fetch_ctrl #(
    parameter bit          ALIGN_CHECK = 1'b1,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic        mem_arvalid,
    output logic [31:0] mem_araddr,
    input  logic        mem_arready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    output logic        mem_rready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        fault_o
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t      state;
    logic [31:0] pcReg;
    logic [31:0] instReg;
    logic        faultReg;
    logic        arvalidReg;
    logic        rreadyReg;
    logic        outValidReg;
    logic        reqFire;

    function automatic logic isMisaligned(input logic [31:0] pc);
        return ALIGN_CHECK && (pc[1:0] != 2'b00);
    endfunction

    // Depends only on the registered state and out_ready, never on mem_*.
    assign req_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    assign reqFire   = req_valid && req_ready;

    assign mem_arvalid = arvalidReg;
    assign mem_araddr  = pcReg;
    assign mem_rready  = rreadyReg;
    assign out_valid   = outValidReg;
    assign out_pc      = pcReg;
    assign out_inst    = instReg;
    assign fault_o     = faultReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pcReg       <= 32'h0;
            instReg     <= 32'h0;
            faultReg    <= 1'b0;
            arvalidReg  <= 1'b0;
            rreadyReg   <= 1'b0;
            outValidReg <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (reqFire) begin
                        pcReg <= req_pc;
                        if (isMisaligned(req_pc)) begin
                            // Misaligned PC never reaches the bus; the fault
                            // result is presented on the very next cycle.
                            state       <= HOLD;
                            instReg     <= NOP_INST;
                            faultReg    <= 1'b1;
                            outValidReg <= 1'b1;
                            arvalidReg  <= 1'b0;
                        end else begin
                            state       <= ADDR;
                            faultReg    <= 1'b0;
                            outValidReg <= 1'b0;
                            arvalidReg  <= 1'b1;
                        end
                    end else if ((state == HOLD) && out_ready) begin
                        state       <= IDLE;
                        outValidReg <= 1'b0;
                    end
                end
                ADDR: begin
                    // araddr is pcReg, which cannot change until the
                    // fetch completes, so it stays stable while waiting.
                    if (mem_arready) begin
                        state      <= DATA;
                        arvalidReg <= 1'b0;
                        rreadyReg  <= 1'b1;
                    end
                end
                DATA: begin
                    if (mem_rvalid) begin
                        state       <= HOLD;
                        rreadyReg   <= 1'b0;
                        outValidReg <= 1'b1;
                        faultReg    <= (mem_rresp != 2'b00);
                        instReg     <= (mem_rresp != 2'b00) ? NOP_INST : mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_ifu_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc = 32'h0;
    logic        req_ready;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [1:0]  mem_rresp = 2'b00;
    logic        mem_rready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        fault_o;

    localparam logic [31:0] NOP = 32'h0000_0013;

    ifu_fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
        .mem_rready(mem_rready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory slave configuration, set by the directed sequence.
    int          arWait = 0;
    int          rWait = 0;
    logic [31:0] memRdata = 32'h0;
    logic [1:0]  memRresp = 2'b00;

    // Timing inside a cycle (negedge at +0): stimulus +1, slave +2,
    // model compare +3, directed checks +4.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory slave: counts wait cycles, then answers.
    initial begin : slave
        int phase = 0;
        int arCnt = 0;
        int rCnt = 0;
        forever begin
            @(negedge clk);
            #2;
            mem_arready = 1'b0;
            mem_rvalid  = 1'b0;
            if (rst) begin
                phase = 0; arCnt = 0; rCnt = 0;
            end else if (phase == 1) begin
                if (rCnt == rWait) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = memRdata;
                    mem_rresp  = memRresp;
                    phase = 0;
                end else begin
                    rCnt++;
                end
            end else if (mem_arvalid) begin
                if (arCnt == arWait) begin
                    mem_arready = 1'b1;
                    phase = 1; rCnt = 0; arCnt = 0;
                end else begin
                    arCnt++;
                end
            end
        end
    end

    // Transaction-level model: tracks which phase the single outstanding
    // fetch is in and what result Decode must see, then compares every cycle.
    initial begin : model
        bit          live = 0;
        bit          postReset = 0;
        bit          busy = 0, addrPend = 0, dataPend = 0, avail = 0;
        logic [31:0] pendPc = 0, expPc = 0, expInst = 0;
        logic        expFault = 0;
        logic        expReqReady;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                live = 1; postReset = 1;
                busy = 0; addrPend = 0; dataPend = 0; avail = 0;
            end else if (live) begin
                expReqReady = !busy || (avail && out_ready);
                chk("m_req_ready", {31'b0, req_ready}, {31'b0, expReqReady});
                chk("m_out_valid", {31'b0, out_valid}, {31'b0, avail});
                chk("m_arvalid", {31'b0, mem_arvalid}, {31'b0, addrPend});
                chk("m_rready", {31'b0, mem_rready}, {31'b0, dataPend});
                if (addrPend) chk("m_araddr", mem_araddr, pendPc);
                if (avail) begin
                    chk("m_out_pc", out_pc, expPc);
                    chk("m_out_inst", out_inst, expInst);
                    chk("m_fault", {31'b0, fault_o}, {31'b0, expFault});
                end
                if (postReset) begin
                    chk("m_rst_araddr", mem_araddr, 32'h0);
                    chk("m_rst_out_inst", out_inst, 32'h0);
                    chk("m_rst_fault", {31'b0, fault_o}, 32'h0);
                end
                postReset = 0;
                // Events of this cycle take effect in the next one.
                if (avail && out_ready) begin
                    avail = 0; busy = 0;
                end
                if (dataPend && mem_rvalid) begin
                    dataPend = 0; avail = 1;
                    expPc    = pendPc;
                    expFault = (mem_rresp != 2'b00);
                    expInst  = expFault ? NOP : mem_rdata;
                end
                if (addrPend && mem_arready) begin
                    addrPend = 0; dataPend = 1;
                end
                if (req_valid && expReqReady) begin
                    busy = 1;
                    if (req_pc[1:0] != 2'b00) begin
                        avail = 1; expPc = req_pc; expInst = NOP; expFault = 1;
                    end else begin
                        addrPend = 1; pendPc = req_pc;
                    end
                end
            end
        end
    end

    // Waits (bounded) until out_valid; returns cycles since startCyc.
    task automatic waitOut(input int startCyc, output int lat);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            #3;
            n++;
        end
        if (!out_valid) begin
            errors++;
            $display("FAIL wait_out_valid: timed out after %0d cycles", n);
        end
        lat = cyc - startCyc;
    endtask

    task automatic consume();
        tick(); out_ready = 1'b1; req_valid = 1'b0;
        tick(); out_ready = 1'b0;
    endtask

    // Issues an aligned request (accepted in the current cycle) and returns
    // the accept cycle.
    task automatic issue(input logic [31:0] pc, output int c0);
        tick(); req_valid = 1'b1; req_pc = pc; out_ready = 1'b0;
        #3;
        chk("req_accept", {31'b0, req_ready}, 32'h1);
        c0 = cyc;
        tick(); req_valid = 1'b0;
        #3;
    endtask

    initial begin : directed
        int c0;
        int lat;
        int n;
        tick(); rst = 1'b1;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        #3;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_arvalid", {31'b0, mem_arvalid}, 32'h0);
        chk("rst_rready", {31'b0, mem_rready}, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_araddr", mem_araddr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_fault", {31'b0, fault_o}, 32'h0);

        // Zero-wait fetch.
        memRdata = 32'h0010_0093; memRresp = 2'b00; arWait = 0; rWait = 0;
        issue(32'h8000_0000, c0);
        chk("t1_arvalid_c1", {31'b0, mem_arvalid}, 32'h1);
        chk("t1_araddr_c1", mem_araddr, 32'h8000_0000);
        waitOut(c0, lat);
        chk("t1_latency", lat, 32'd3);
        chk("t1_out_pc", out_pc, 32'h8000_0000);
        chk("t1_out_inst", out_inst, 32'h0010_0093);
        chk("t1_fault", {31'b0, fault_o}, 32'h0);
        consume();

        // Wait states: 2 on arready, 3 on rvalid.
        memRdata = 32'h0000_8067; arWait = 2; rWait = 3;
        issue(32'h8000_0100, c0);
        waitOut(c0, lat);
        chk("t2_latency", lat, 32'd8);
        chk("t2_out_inst", out_inst, 32'h0000_8067);
        consume();
        arWait = 0; rWait = 0;

        // Downstream stall with a pending request.
        memRdata = 32'h0020_0113;
        issue(32'h8000_0000, c0);
        waitOut(c0, lat);
        memRdata = 32'h0030_0193;
        for (int i = 0; i < 5; i++) begin
            tick(); req_valid = 1'b1; req_pc = 32'h8000_0004; out_ready = 1'b0;
            #3;
            chk("t3_stall_req_ready", {31'b0, req_ready}, 32'h0);
            chk("t3_stall_out_pc", out_pc, 32'h8000_0000);
            chk("t3_stall_out_inst", out_inst, 32'h0020_0113);
        end
        tick(); out_ready = 1'b1;
        #3;
        chk("t3_release_req_ready", {31'b0, req_ready}, 32'h1);
        c0 = cyc;
        tick(); req_valid = 1'b0; out_ready = 1'b0;
        #3;
        chk("t3_new_araddr", mem_araddr, 32'h8000_0004);
        chk("t3_new_arvalid", {31'b0, mem_arvalid}, 32'h1);
        waitOut(c0, lat);
        chk("t3_out_inst", out_inst, 32'h0030_0193);
        consume();

        // Misaligned PC.
        tick(); req_valid = 1'b1; req_pc = 32'h8000_0002;
        #3;
        c0 = cyc;
        tick(); req_valid = 1'b0;
        #3;
        chk("t4_latency", cyc - c0, 32'd1);
        chk("t4_out_valid", {31'b0, out_valid}, 32'h1);
        chk("t4_arvalid", {31'b0, mem_arvalid}, 32'h0);
        chk("t4_fault", {31'b0, fault_o}, 32'h1);
        chk("t4_out_inst", out_inst, NOP);
        chk("t4_out_pc", out_pc, 32'h8000_0002);
        consume();

        // Error response.
        memRdata = 32'hDEAD_BEEF; memRresp = 2'b10;
        issue(32'h8000_0008, c0);
        waitOut(c0, lat);
        chk("t5_latency", lat, 32'd3);
        chk("t5_fault", {31'b0, fault_o}, 32'h1);
        chk("t5_out_inst", out_inst, NOP);
        consume();
        memRresp = 2'b00;

        // Reset while waiting in DATA.
        rWait = 20;
        issue(32'h8000_000C, c0);
        n = 0;
        while (!mem_rready && n < 20) begin
            tick(); #3; n++;
        end
        chk("t6_reached_data", {31'b0, mem_rready}, 32'h1);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        #3;
        chk("t6_out_valid", {31'b0, out_valid}, 32'h0);
        chk("t6_rready", {31'b0, mem_rready}, 32'h0);
        chk("t6_req_ready", {31'b0, req_ready}, 32'h1);
        chk("t6_arvalid", {31'b0, mem_arvalid}, 32'h0);
        rWait = 0;

        // Recovery fetch after the mid-fetch reset.
        memRdata = 32'h0000_0513;
        issue(32'h8000_0010, c0);
        waitOut(c0, lat);
        chk("t7_latency", lat, 32'd3);
        chk("t7_out_inst", out_inst, 32'h0000_0513);
        chk("t7_out_pc", out_pc, 32'h8000_0010);
        consume();

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Instruction-fetch controller between the PC register and the Decode-stage pipeline register. It takes a fetch request carrying a PC, issues a single-beat read on an AXI4-Lite-style read channel to instruction memory, and captures the returned word. It then presents `{pc, inst, fault}` downstream under a valid/ready handshake, holding the result until Decode accepts it. At most one fetch is outstanding; a new request is accepted in the same cycle the held result is consumed.

## Interface
Parameters:
- `ALIGN_CHECK`, 1: when 1, a PC with `pc[1:0]!=0` is not sent to memory and returns a fault.
- `NOP_INST`, 32'h0000_0013: instruction word presented when `fault_o=1`.

Ports:
- `clk`  in  1  single clock, all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  upstream fetch request.
- `req_pc`  in  32  PC to fetch; sampled on the request handshake.
- `req_ready`  out  1  controller can accept a request this cycle.
- `mem_arvalid`  out  1  read-address valid.
- `mem_araddr`  out  32  read address; equals the latched PC.
- `mem_arready`  in  1  slave accepted the address.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read data.
- `mem_rresp`  in  2  read response; nonzero means access fault.
- `mem_rready`  out  1  controller accepts read data.
- `out_valid`  out  1  fetched instruction available.
- `out_ready`  in  1  Decode accepts it.
- `out_pc`  out  32  PC of the presented instruction.
- `out_inst`  out  32  instruction word.
- `fault_o`  out  1  misaligned PC or nonzero `rresp`.

## Operation
- States: IDLE, ADDR, DATA, HOLD. Reset puts the FSM in IDLE.
- Reset values: `req_ready=1`, `mem_arvalid=0`, `mem_rready=0`, `out_valid=0`. `mem_araddr`, `out_pc` and `out_inst` reset to 0. `fault_o=0`.
- `req_ready = (state==IDLE) | (state==HOLD & out_ready)`.
- Request handshake (`req_valid & req_ready`):
  - Latch `req_pc`.
  - Aligned PC, or `ALIGN_CHECK=0`: go to ADDR.
  - Misaligned PC with `ALIGN_CHECK=1`: go straight to HOLD with `out_inst=NOP_INST` and `fault_o=1`. No bus activity.
- ADDR:
  - `mem_arvalid=1`, `mem_araddr=latched PC`.
  - On `mem_arready`, go to DATA.
  - `arvalid` stays asserted and `araddr` stays stable until `arready`.
- DATA:
  - `mem_rready=1`.
  - On `mem_rvalid`, capture `mem_rdata` into `out_inst` and set `fault_o = (mem_rresp!=0)`. Go to HOLD.
  - When `rresp!=0`, `out_inst=NOP_INST` and `mem_rdata` is ignored.
- HOLD:
  - `out_valid=1`. `out_pc`, `out_inst` and `fault_o` hold stable until `out_ready`.
  - On `out_ready` with a simultaneous request: latch the new PC and go to ADDR, or go to HOLD if the new PC is misaligned.
  - On `out_ready` with no request: go to IDLE.
- `mem_rvalid` seen outside DATA is ignored. `mem_rready=0` outside DATA.
- Reset mid-fetch (any state): return to IDLE and drop the transaction. The memory slave shares `rst`, so no stale beat returns.
- `out_valid` and `req_ready` never depend combinationally on `mem_*` inputs.

## Timing
- Zero-wait memory (`arready=1`, `rvalid` one cycle after address):
  - Cycle 0: request accepted.
  - Cycle 1: ADDR, address handshake.
  - Cycle 2: DATA, data handshake.
  - Cycle 3: `out_valid=1`.
  - Fetch latency is 3 cycles.
- Back-to-back: the next request is accepted in the HOLD cycle where `out_ready=1`. Throughput is one instruction per 3 cycles.
- Misaligned fault: `out_valid` rises 1 cycle after the request.
- Each `arready` wait cycle adds 1 cycle. Each `rvalid` wait cycle adds 1 cycle.
- Downstream stall holds `out_*` indefinitely with no change.

## Test plan
- Reset, then `req_pc=0x8000_0000` with memory returning `0x0010_0093` and zero wait states. Required: `araddr=0x8000_0000` in cycle 1; `out_valid` in cycle 3 with `out_pc=0x8000_0000`, `out_inst=0x0010_0093`, `fault_o=0`.
- Memory inserts 2 `arready` wait cycles and 3 `rvalid` wait cycles. Required: `araddr` stable throughout, `out_valid` at cycle 8, `out_inst` correct.
- `out_ready=0` for 5 cycles while in HOLD and `req_valid=1`. Required: `out_*` stable and `req_ready=0`. When `out_ready` rises, the new PC `0x8000_0004` is latched the same cycle.
- `req_pc=0x8000_0002`. Required: no `arvalid`; next cycle `out_valid=1`, `fault_o=1`, `out_inst=0x0000_0013`.
- `rresp=2'b10` with `rdata=0xDEAD_BEEF`. Required: `fault_o=1`, `out_inst=0x0000_0013`.
- Assert `rst` while in DATA. Required: next cycle IDLE, `out_valid=0`, `mem_rready=0`, `req_ready=1`.
